// File: rtl/udp_line_tx_scheduler.sv
// udp_line_tx_scheduler
// Paces the GMII line sender from the capture FIFO fill level: one transmit
// request per buffered video line, line-number tagging, a fixed inter-packet
// gap and frame boundary tracking. Single clock domain (GMII tx clock).
module udp_line_tx_scheduler #(
    parameter int LINE_BYTES  = 960,
    parameter int LINES_FRAME = 160,
    parameter int GAP_CYCLES  = 24,
    parameter int FIFO_BYTES  = 2047
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_sync,
    input  logic [10:0] rnum,
    output logic        tx_req,
    input  logic        tx_ack,
    input  logic        tx_done,
    output logic [7:0]  tx_line,
    output logic [10:0] tx_len,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf_sticky
);

    localparam int          GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [10:0] LINE_LEN  = 11'(LINE_BYTES);
    localparam logic [10:0] FIFO_FULL = 11'(FIFO_BYTES);
    localparam logic [7:0]  LAST_LINE = 8'(LINES_FRAME - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             resync_pend;

    // Scheduler FSM; every output is a register updated alongside the state.
    // A frame_sync seen while a packet is in flight is deferred until that
    // packet's tx_done so the header line number never changes mid-packet.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tx_req      <= 1'b0;
            tx_line     <= '0;
            tx_len      <= LINE_LEN;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            ovf_sticky  <= 1'b0;
            gap_cnt     <= '0;
            resync_pend <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            tx_len     <= LINE_LEN;
            if (rnum >= FIFO_FULL) begin
                ovf_sticky <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_sync) begin
                        tx_line <= '0;
                    end
                    if (enable) begin
                        state <= ST_WAIT;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (frame_sync) begin
                        tx_line <= '0;
                    end
                    if (!enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rnum >= LINE_LEN) begin
                        state  <= ST_REQ;
                        tx_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (frame_sync) begin
                        resync_pend <= 1'b1;
                    end
                    if (tx_ack) begin
                        state  <= ST_SEND;
                        tx_req <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        state   <= ST_GAP;
                        gap_cnt <= GAP_LOAD;
                        if (resync_pend || frame_sync) begin
                            tx_line     <= '0;
                            resync_pend <= 1'b0;
                        end else if (tx_line == LAST_LINE) begin
                            tx_line    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            tx_line <= tx_line + 8'd1;
                        end
                    end else if (frame_sync) begin
                        resync_pend <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (frame_sync) begin
                        tx_line <= '0;
                    end
                    if (gap_cnt == '0) begin
                        if (enable) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
